// File: rtl/calc_pkg.sv
// Shared definitions for the calculator result path: FSM encoding, default
// operand/digit widths and the largest value representable in N_DIG BCD digits.
package calc_pkg;

    localparam int N_BIN_DEF = 17;
    localparam int N_DIG_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // 10^n_dig - 1; values above this saturate the display to all nines.
    function automatic logic [63:0] bcd_limit(input int n_dig);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < n_dig; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

    localparam logic [63:0] BCD_LIMIT_DEF = bcd_limit(N_DIG_DEF);

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] y
);

    assign y = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per cycle,
// with saturation to all nines when the operand exceeds the digit range.
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int N_BIN = N_BIN_DEF,
    parameter int N_DIG = N_DIG_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_BIN-1:0]   bin,
    input  logic               neg_in,
    output logic [4*N_DIG-1:0] q,
    output logic               neg,
    output logic               ovf,
    output logic               busy,
    output logic               done
);

    localparam int BCD_W = 4 * N_DIG;
    localparam int CNT_W = $clog2(N_BIN + 1);
    localparam logic [63:0] LIMIT = bcd_limit(N_DIG);
    localparam logic [BCD_W-1:0] ALL_NINES = {N_DIG{4'h9}};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_BIN-1:0]   sr_q, sr_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_flag_q, ovf_flag_d;
    logic               neg_flag_q, neg_flag_d;
    logic [BCD_W-1:0]   q_q, q_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W+N_BIN-1:0] shifted;

    for (genvar i = 0; i < N_DIG; i++) begin : g_add3
        bcd_add3 u_add3 (
            .d (bcd_q[4*i +: 4]),
            .y (bcd_adj[4*i +: 4])
        );
    end

    assign shifted = {bcd_adj, sr_q} << 1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sr_d       = sr_q;
        bcd_d      = bcd_q;
        ovf_flag_d = ovf_flag_q;
        neg_flag_d = neg_flag_q;
        q_d        = q_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SHIFT;
                    cnt_d      = CNT_W'(N_BIN);
                    sr_d       = bin;
                    bcd_d      = '0;
                    neg_flag_d = neg_in;
                    ovf_flag_d = (64'(bin) > LIMIT);
                end
            end
            ST_SHIFT: begin
                bcd_d = shifted[BCD_W+N_BIN-1 -: BCD_W];
                sr_d  = shifted[N_BIN-1:0];
                cnt_d = cnt_q - CNT_W'(1);
                // Results are published from the final shift so the visible
                // outputs only ever change on the edge that enters DONE.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    q_d     = ovf_flag_q ? ALL_NINES : shifted[BCD_W+N_BIN-1 -: BCD_W];
                    neg_d   = neg_flag_q;
                    ovf_d   = ovf_flag_q;
                    done_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            bcd_q      <= '0;
            ovf_flag_q <= 1'b0;
            neg_flag_q <= 1'b0;
            q_q        <= '0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            bcd_q      <= bcd_d;
            ovf_flag_q <= ovf_flag_d;
            neg_flag_q <= neg_flag_d;
            q_q        <= q_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign q    = q_q;
    assign neg  = neg_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: decimal reference model plus directed and random runs.
module tb_bin2bcd_seq;

    localparam int N_BIN = 17;
    localparam int N_DIG = 5;
    localparam int unsigned LIMIT = 10**N_DIG - 1;

    logic               clk;
    logic               rst;
    logic               start;
    logic [N_BIN-1:0]   bin;
    logic               neg_in;
    logic [4*N_DIG-1:0] q;
    logic               neg;
    logic               ovf;
    logic               busy;
    logic               done;

    int n_asrt = 0;
    int n_fail = 0;
    logic cmp_en = 1'b0;

    bin2bcd_seq #(.N_BIN(N_BIN), .N_DIG(N_DIG)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bin    (bin),
        .neg_in (neg_in),
        .q      (q),
        .neg    (neg),
        .ovf    (ovf),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal digits by repeated division; saturate above the digit range.
    function automatic logic [4*N_DIG-1:0] exp_bcd(input int unsigned v);
        logic [4*N_DIG-1:0] r;
        int unsigned        x;
        r = '0;
        x = v;
        if (v > LIMIT) begin
            for (int i = 0; i < N_DIG; i++) r[4*i +: 4] = 4'h9;
        end else begin
            for (int i = 0; i < N_DIG; i++) begin
                r[4*i +: 4] = 4'(x % 10);
                x = x / 10;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_asrt++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference: a request is accepted when idle, busy lasts N_BIN+1 cycles,
    // results appear together with done in the last busy cycle.
    int                 m_rem = 0;
    logic [4*N_DIG-1:0] m_q = '0;
    logic               m_neg = 1'b0;
    logic               m_ovf = 1'b0;
    logic               m_done = 1'b0;
    int unsigned        m_val = 0;
    logic               m_nval = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_rem  <= 0;
            m_q    <= '0;
            m_neg  <= 1'b0;
            m_ovf  <= 1'b0;
            m_done <= 1'b0;
        end else if (m_rem == 0) begin
            m_done <= 1'b0;
            if (start) begin
                m_rem  <= N_BIN + 1;
                m_val  <= 32'(bin);
                m_nval <= neg_in;
            end
        end else begin
            m_rem  <= m_rem - 1;
            m_done <= (m_rem == 2);
            if (m_rem == 2) begin
                m_q   <= exp_bcd(m_val);
                m_neg <= m_nval;
                m_ovf <= (m_val > LIMIT);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("q", 32'(q), 32'(m_q));
            chk("neg", 32'(neg), 32'(m_neg));
            chk("ovf", 32'(ovf), 32'(m_ovf));
            chk("busy", 32'(busy), 32'(m_rem != 0));
            chk("done", 32'(done), 32'(m_done));
        end
    end

    // Starts one conversion from an idle negedge, waits for done, checks the
    // result against literals, and returns in the first idle cycle afterwards.
    task automatic conv(input string name, input logic [N_BIN-1:0] v, input logic n,
                        input logic [4*N_DIG-1:0] want_q, input logic want_ovf);
        int lat;
        start  = 1'b1;
        bin    = v;
        neg_in = n;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'd18);
        chk({name, "_q"}, 32'(q), 32'(want_q));
        chk({name, "_ovf"}, 32'(ovf), 32'(want_ovf));
        chk({name, "_neg"}, 32'(neg), 32'(n));
        chk({name, "_model_q"}, 32'(m_q), 32'(want_q));
        @(negedge clk);
    endtask

    initial begin
        int d1, d2, nd, rc;
        rst    = 1'b0;
        start  = 1'b0;
        bin    = '0;
        neg_in = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_neg", 32'(neg), 32'h0);
        cmp_en = 1'b1;
        rst = 1'b1;
        @(negedge clk);

        conv("zero", 17'd0, 1'b0, 20'h00000, 1'b0);
        conv("v12345", 17'd12345, 1'b1, 20'h12345, 1'b0);
        repeat (5) @(negedge clk);
        chk("hold_q", 32'(q), 32'h12345);
        chk("hold_neg", 32'(neg), 32'h1);
        chk("hold_done", 32'(done), 32'h0);

        conv("v99999", 17'd99999, 1'b0, 20'h99999, 1'b0);
        conv("v100000", 17'd100000, 1'b0, 20'h99999, 1'b1);
        conv("vmax", 17'h1FFFF, 1'b1, 20'h99999, 1'b1);

        // Starts during a conversion are dropped; the first idle cycle accepts.
        start = 1'b1;
        bin   = 17'd500;
        d1 = -1; d2 = -1; nd = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (d1 < 0) begin
                    d1 = c;
                    chk("b2b_q500", 32'(q), 32'h00500);
                end else if (d2 < 0) begin
                    d2 = c;
                    chk("b2b_q7", 32'(q), 32'h00007);
                end
            end
            start = (c == 5 || c == 18 || c == 19);
            bin   = 17'd7;
        end
        chk("b2b_first_done", 32'(d1), 32'd18);
        chk("b2b_second_done", 32'(d2), 32'd37);
        chk("b2b_done_count", 32'(nd), 32'd2);

        // Reset in the middle of a conversion, with start held high meanwhile.
        start = 1'b1;
        bin   = 17'd4321;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_q", 32'(q), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        rst   = 1'b1;
        start = 1'b0;
        nd = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        chk("abort_q_held", 32'(q), 32'h0);
        conv("v4321", 17'd4321, 1'b0, 20'h04321, 1'b0);

        // Random operands, start noise while busy, occasional mid-run resets.
        for (int it = 0; it < 150; it++) begin
            int sel;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sel = $urandom_range(0, 3);
            case (sel)
                0: bin = 17'($urandom_range(0, 9));
                1: bin = 17'($urandom_range(99990, 100010));
                default: bin = 17'($urandom);
            endcase
            neg_in = 1'($urandom_range(0, 1));
            start  = 1'b1;
            rc = ($urandom_range(0, 9) == 0) ? $urandom_range(2, 16) : 0;
            for (int c = 1; c <= 18; c++) begin
                @(negedge clk);
                start  = ($urandom_range(0, 3) == 0);
                bin    = 17'($urandom);
                neg_in = 1'($urandom_range(0, 1));
                if (rc != 0 && c == rc) rst = 1'b0;
                else rst = 1'b1;
            end
            @(negedge clk);
            rst   = 1'b1;
            start = 1'b0;
        end
        repeat (25) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
